// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer helpers for the async FIFO control stages.
//   PTR_WIDTH_DEF / DEPTH_DEF : default pointer address width and depth.
//   bin2gray / gray2bin       : code conversions on zero-padded 32-bit
//                               vectors, so they work for any pointer width
//                               up to 32 bits. Callers cast in and out.
//   full_cmp                  : the Gray value the write pointer takes when
//                               it is exactly one lap ahead of the read
//                               pointer (top two Gray bits inverted).
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int DEPTH_DEF     = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits must be zero; each binary bit is the XOR of all Gray bits
    // at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // w is the full pointer width (address bits + wrap bit), w >= 3.
    function automatic logic [31:0] full_cmp(input logic [31:0] g, input int w);
        return g ^ (32'd3 << (w - 2));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a Gray-coded pointer crossing into the
// local clock domain. Asynchronous active-high reset clears both stages.
//   wclk : destination clock
//   wrst : asynchronous active-high reset
//   d    : unsynchronized input (WIDTH bits)
//   q    : synchronized output, two edges after d
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side control of the async FIFO (wclk domain).
// Keeps the binary/Gray write pointers, synchronizes the read Gray pointer,
// and registers full, almost_full, fill level, write ack and overflow.
//   wclk, wrst    : write clock, asynchronous active-high reset
//   wr_en         : write request; accepted when full is low
//   g_rptr_async  : Gray read pointer from the rclk domain
//   ovf_clr       : clears the sticky overflow flag
//   b_wptr        : binary write pointer (memory address = low PTR_WIDTH bits)
//   g_wptr        : Gray write pointer to the read-side synchronizer
//   full, almost_full, wr_level : occupancy as seen from wclk
//   wr_ack        : a write was accepted on the previous edge
//   overflow      : sticky, set by a write attempt while full
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int AFULL_THRESH = 6
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               wr_en,
    input  logic [PTR_WIDTH:0] g_rptr_async,
    input  logic               ovf_clr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_level,
    output logic               wr_ack,
    output logic               overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AFULL_T = PW'(AFULL_THRESH);

    if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
        $error("fifo_wptr_full: DEPTH must equal 2**PTR_WIDTH");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_full: AFULL_THRESH out of range 1..DEPTH");
    end

    logic [PTR_WIDTH:0] rq2;
    logic [PTR_WIDTH:0] rbin;
    logic               acc;
    logic [PTR_WIDTH:0] b_next, g_next, diff;

    logic [PTR_WIDTH:0] b_wptr_d, b_wptr_q;
    logic [PTR_WIDTH:0] g_wptr_d, g_wptr_q;
    logic [PTR_WIDTH:0] level_d, level_q;
    logic               full_d, full_q;
    logic               afull_d, afull_q;
    logic               ack_d, ack_q;
    logic               ovf_d, ovf_q;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .wclk (wclk),
        .wrst (wrst),
        .d    (g_rptr_async),
        .q    (rq2)
    );

    always_comb begin
        acc    = wr_en & ~full_q;
        b_next = b_wptr_q + PW'(acc);
        g_next = PW'(bin2gray(32'(b_next)));
        rbin   = PW'(gray2bin(32'(rq2)));
        // Modulo subtraction; the wrap bit keeps this within 0..DEPTH.
        diff   = b_next - rbin;

        b_wptr_d = b_next;
        g_wptr_d = g_next;
        // Compare the next pointer so full rises on the edge that
        // registers the DEPTH-th outstanding write.
        full_d   = (g_next == PW'(full_cmp(32'(rq2), PW)));
        level_d  = diff;
        afull_d  = (diff >= AFULL_T);
        ack_d    = acc;
        // A new overflow event beats a simultaneous clear.
        ovf_d    = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;
    assign wr_ack      = ack_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed bench for the write-side FIFO control stage
// with PTR_WIDTH=3, DEPTH=8, AFULL_THRESH=6.
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       wr_en;
    logic [3:0] g_rptr_async;
    logic       ovf_clr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       wr_ack;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wptr_full #(.PTR_WIDTH(3), .DEPTH(8), .AFULL_THRESH(6)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .wr_en        (wr_en),
        .g_rptr_async (g_rptr_async),
        .ovf_clr      (ovf_clr),
        .b_wptr       (b_wptr),
        .g_wptr       (g_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .wr_ack       (wr_ack),
        .overflow     (overflow)
    );

    always #5 wclk = ~wclk;

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        wrst    = 1'b1;
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        tick();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        g_rptr_async = 4'b0000;
        apply_reset();
        n_cmp++;
        if ({b_wptr, g_wptr, wr_level, full, almost_full, wr_ack, overflow} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_state: got b=%b g=%b lvl=%0d f=%b af=%b ack=%b ovf=%b, want all 0",
                     b_wptr, g_wptr, wr_level, full, almost_full, wr_ack, overflow);
        end
        wr_en = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (b_wptr !== 4'd3) begin
            n_bad++; $display("FAIL pre_reset_b: got %0d want 3", b_wptr);
        end
        wr_en = 1'b0;
        #3 wrst = 1'b1;
        #1;
        n_cmp++;
        if ({b_wptr, g_wptr, wr_level, full, almost_full, wr_ack, overflow} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: got b=%b g=%b lvl=%0d ack=%b, want all 0",
                     b_wptr, g_wptr, wr_level, wr_ack);
        end
        #1 wrst = 1'b0;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (b_wptr !== 4'd1 || g_wptr !== 4'b0001 || wr_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL first_write_after_reset: got b=%0d g=%b ack=%b want b=1 g=0001 ack=1",
                     b_wptr, g_wptr, wr_ack);
        end
    endtask

    task automatic test_fill();
        g_rptr_async = 4'b0000;
        apply_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_cmp++;
            if (i <= 8) begin
                if (b_wptr !== 4'(i) || wr_ack !== 1'b1 || full !== (i == 8)) begin
                    n_bad++;
                    $display("FAIL fill_step%0d: got b=%0d ack=%b full=%b want b=%0d ack=1 full=%b",
                             i, b_wptr, wr_ack, full, i, (i == 8));
                end
            end else begin
                if (b_wptr !== 4'd8 || wr_ack !== 1'b0 || full !== 1'b1) begin
                    n_bad++;
                    $display("FAIL fill_ignored: got b=%0d ack=%b full=%b want b=8 ack=0 full=1",
                             b_wptr, wr_ack, full);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (g_wptr !== 4'b1100 || wr_level !== 4'd8) begin
                    n_bad++;
                    $display("FAIL fill_full_state: got g=%b lvl=%0d want g=1100 lvl=8",
                             g_wptr, wr_level);
                end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        ovf_clr = 1'b1; wr_en = 1'b0; tick();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clear_initial: got %b want 0", overflow);
        end
        ovf_clr = 1'b0; wr_en = 1'b1; tick();
        n_cmp++;
        if (overflow !== 1'b1 || wr_ack !== 1'b0 || b_wptr !== 4'd8) begin
            n_bad++;
            $display("FAIL ovf_set: got ovf=%b ack=%b b=%0d want ovf=1 ack=0 b=8",
                     overflow, wr_ack, b_wptr);
        end
        wr_en = 1'b0; tick();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        wr_en = 1'b1; ovf_clr = 1'b1; tick();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_set_beats_clr: got %b want 1", overflow);
        end
        wr_en = 1'b0; ovf_clr = 1'b1; tick();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clr: got %b want 0", overflow);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_drain();
        g_rptr_async = 4'b0010;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (e < 3) begin
                if (full !== 1'b1 || wr_level !== 4'd8) begin
                    n_bad++;
                    $display("FAIL drain_early_e%0d: got full=%b lvl=%0d want full=1 lvl=8",
                             e, full, wr_level);
                end
            end else begin
                if (full !== 1'b0 || wr_level !== 4'd5 || almost_full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL drain_visible: got full=%b lvl=%0d af=%b want full=0 lvl=5 af=0",
                             full, wr_level, almost_full);
                end
            end
        end
    endtask

    task automatic test_almost_full();
        g_rptr_async = 4'b0000;
        apply_reset();
        wr_en = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (almost_full !== 1'b0 || wr_level !== 4'd5) begin
            n_bad++;
            $display("FAIL afull_at5: got af=%b lvl=%0d want af=0 lvl=5", almost_full, wr_level);
        end
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (almost_full !== 1'b1 || wr_level !== 4'd6) begin
            n_bad++;
            $display("FAIL afull_at6: got af=%b lvl=%0d want af=1 lvl=6", almost_full, wr_level);
        end
        g_rptr_async = 4'b0001;
        repeat (2) tick();
        n_cmp++;
        if (almost_full !== 1'b1) begin
            n_bad++; $display("FAIL afull_early_drop: got %b want 1", almost_full);
        end
        tick();
        n_cmp++;
        if (almost_full !== 1'b0 || wr_level !== 4'd5) begin
            n_bad++;
            $display("FAIL afull_drop: got af=%b lvl=%0d want af=0 lvl=5", almost_full, wr_level);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_b;
        logic [3:0] exp_g;
        logic [3:0] prev_g;
        int         wraps;
        g_rptr_async = 4'b0000;
        apply_reset();
        exp_b  = 4'd0;
        prev_g = 4'd0;
        wraps  = 0;
        for (int i = 1; i <= 40; i++) begin
            wr_en = 1'b1;
            tick();
            exp_b = exp_b + 4'd1;
            exp_g = exp_b ^ (exp_b >> 1);
            n_cmp++;
            if (b_wptr !== exp_b || g_wptr !== exp_g || wr_ack !== 1'b1 || full !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_step%0d: got b=%0d g=%b ack=%b full=%b want b=%0d g=%b ack=1 full=0",
                         i, b_wptr, g_wptr, wr_ack, full, exp_b, exp_g);
            end
            n_cmp++;
            if ($countones(g_wptr ^ prev_g) != 1) begin
                n_bad++;
                $display("FAIL wrap_gray_step%0d: got %b after %b, want one bit change",
                         i, g_wptr, prev_g);
            end
            n_cmp++;
            if (wr_level !== ((i < 3) ? 4'(i) : 4'd3)) begin
                n_bad++;
                $display("FAIL wrap_level%0d: got %0d want %0d", i, wr_level, (i < 3) ? i : 3);
            end
            if (exp_b == 4'd0) begin
                wraps++;
                n_cmp++;
                if (prev_g !== 4'b1000 || g_wptr !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL wrap_gray_rollover: got %b -> %b want 1000 -> 0000",
                             prev_g, g_wptr);
                end
            end
            prev_g = g_wptr;
            // Reader consumes everything written so far.
            g_rptr_async = exp_g;
        end
        wr_en = 1'b0;
        n_cmp++;
        if (wraps != 2) begin
            n_bad++; $display("FAIL wrap_count: got %0d want 2", wraps);
        end
    endtask

    initial begin
        wrst         = 1'b1;
        wr_en        = 1'b0;
        ovf_clr      = 1'b0;
        g_rptr_async = 4'b0000;
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_almost_full();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
